hp_class_gen: RTL and testbench
===============================

Name: hp_class_gen

Overview:
- Stimulus generator for half-precision (IEEE-754 binary16) classification.
- Enumerates, in ascending bit-pattern order, every 16-bit encoding belonging to a requested set of classes.
- Streams the encodings out over a valid/ready interface, so class checkers downstream can be fed exhaustive per-class sweeps and their counts compared against known totals.

Parameters:
- POS_ONLY, 0, when 1 only sign=0 encodings are enumerated (scan range 0x0000..0x7FFF); when 0 full range 0x0000..0xFFFF.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  synchronous cancel of a running sweep
- class_mask  in  6  one-hot-per-class select {snan,qnan,infinity,zero,subnormal,normal}; captured on accepted start
- f  out  16  current encoding
- f_valid  out  1  f holds a valid encoding
- f_ready  in  1  downstream accepts f when f_valid&&f_ready
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse at sweep end
- count  out  17  number of handshakes completed in current/last sweep

Behaviour:
- Reset values: f=0, f_valid=0, busy=0, done=0, count=0, state IDLE, scan=0, mask register=0.
- Classification of candidate x (e=x[14:10], m=x[9:0]):
  - snan: e=31, m!=0, m[9]=0
  - qnan: e=31, m[9]=1
  - infinity: e=31, m=0
  - zero: e=0, m=0
  - subnormal: e=0, m!=0
  - normal: otherwise
- Exactly one class per x. Candidate matches when class bit AND mask bit = 1.
- States:
  - IDLE: start=1 captures class_mask, clears count, scan=0, busy=1.
    - Mask=0 -> DONE.
    - Otherwise -> SCAN.
  - SCAN: scan register is 17 bits. Advance condition adv = !f_valid || f_ready.
    - When adv:
      - Matching candidate: f<=scan[15:0] and f_valid<=1.
      - Non-matching candidate: f_valid<=0.
      - scan<=scan+1 in both cases.
    - When !adv: scan and f hold; no skipping under backpressure.
    - One candidate is evaluated per advancing cycle.
    - When the last candidate (0xFFFF, or 0x7FFF if POS_ONLY) is evaluated -> DRAIN.
  - DRAIN: f_valid holds until handshake, then drops to 0 -> DONE. If f_valid is already 0 -> DONE next cycle.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: start accepted at cycle N; candidate 0x0000 evaluated at N+1; f_valid visible at N+2 if it matches.
- Maximum throughput is one encoding per cycle within a contiguous matching run.
- count increments on every f_valid&&f_ready, saturating at 0x10000 (full sweep cannot exceed it).
- count holds its value after done until the next accepted start.
- f/f_valid stable while f_valid&&!f_ready.
- start ignored while busy. start and abort in the same IDLE cycle: abort wins, no sweep.
- abort in SCAN/DRAIN: next cycle f_valid=0, busy=0, state IDLE, no done pulse, count retains partial value.
- class_mask changes during a sweep have no effect.
- Reset assertion mid-sweep returns immediately to reset values.
- Expected full-range totals: snan 1022, qnan 1024, infinity 2, zero 2, subnormal 2046, normal 61440; sum 65536. POS_ONLY halves each.

Test Plan:
- mask=6'b001000 (infinity), f_ready=1 -> outputs 0x7C00 then 0xFC00; done pulse; count=2; busy spans about 65537 cycles.
- mask=6'b111111, f_ready=1 -> f sequence 0x0000..0xFFFF with no gaps; f_valid continuous; count=65536.
- mask=6'b100000 (snan), f_ready toggling randomly -> 1022 values, each in 0x7C01..0x7DFF or 0xFC01..0xFDFF; strictly ascending; f stable during stalls; count=1022.
- POS_ONLY=1, mask=6'b000010 (subnormal) -> 0x0001..0x03FF only; count=1023.
- mask=0 -> done two cycles after start; count=0; f_valid never asserted.
- mask=6'b000001, abort after 100 handshakes -> f_valid low next cycle; no done pulse; count=100; a new start then yields a full 61440 sweep.

Source files
------------

// File: rtl/hp_class_gen_if.sv
// Stream of 16-bit half-precision encodings with valid/ready handshake.
// The generator drives the master side; the consumer drives the slave side.
interface hp_class_gen_if;
  logic [15:0] f;
  logic        f_valid;
  logic        f_ready;

  modport master (output f, output f_valid, input f_ready);
  modport slave  (input f, input f_valid, output f_ready);
endinterface

// File: rtl/hp_class_gen.sv
// Ascending sweep of binary16 encodings filtered by class; first candidate 0x0000 reaches f two cycles after start.
// Under backpressure the scan pointer and f hold, so no candidate is skipped; one candidate per advancing cycle.
module hp_class_gen #(
  parameter bit POS_ONLY = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [5:0]     class_mask,
  hp_class_gen_if.master fo,
  output logic           busy,
  output logic           done,
  output logic [16:0]    count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam logic [16:0] LAST    = POS_ONLY ? 17'h07FFF : 17'h0FFFF;
  localparam logic [16:0] CNT_MAX = 17'h10000;

  // Class vector bit order: {snan, qnan, infinity, zero, subnormal, normal}
  function automatic logic [5:0] f_class(input logic [15:0] x);
    logic [4:0] e;
    logic [9:0] m;
    logic [5:0] c;
    e = x[14:10];
    m = x[9:0];
    if (e == 5'd31) begin
      if (m == 10'd0)  c = 6'b001000;
      else if (m[9])   c = 6'b010000;
      else             c = 6'b100000;
    end else if (e == 5'd0) begin
      c = (m == 10'd0) ? 6'b000100 : 6'b000010;
    end else begin
      c = 6'b000001;
    end
    return c;
  endfunction

  state_t      r_state;
  logic [16:0] r_scan;
  logic [5:0]  r_mask;
  logic [15:0] r_f;
  logic        r_f_valid;
  logic        r_busy;
  logic        r_done;
  logic [16:0] r_count;

  logic w_hs;
  logic w_adv;
  logic w_match;
  logic w_last;

  assign w_hs    = r_f_valid & fo.f_ready;
  assign w_adv   = ~r_f_valid | fo.f_ready;
  assign w_match = |(f_class(r_scan[15:0]) & r_mask);
  assign w_last  = (r_scan == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_scan    <= '0;
      r_mask    <= '0;
      r_f       <= '0;
      r_f_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_hs && (r_count != CNT_MAX)) begin
        r_count <= r_count + 17'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_mask  <= class_mask;
            r_count <= '0;
            r_scan  <= '0;
            r_busy  <= 1'b1;
            r_state <= (class_mask == 6'd0) ? S_DONE : S_SCAN;
          end
        end

        S_SCAN: begin
          if (abort) begin
            r_f_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_adv) begin
            if (w_match) begin
              r_f       <= r_scan[15:0];
              r_f_valid <= 1'b1;
            end else begin
              r_f_valid <= 1'b0;
            end
            r_scan <= r_scan + 17'd1;
            if (w_last) begin
              r_state <= S_DRAIN;
            end
          end
        end

        // The last matching encoding may still be waiting for its handshake.
        S_DRAIN: begin
          if (abort) begin
            r_f_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_adv) begin
            r_f_valid <= 1'b0;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fo.f       = r_f;
  assign fo.f_valid = r_f_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign count      = r_count;

endmodule

// File: tb/tb_hp_class_gen.sv
// Directed bench: a full-range and a positive-only generator share start/abort/mask/ready
// and their streams are checked against hand-derived class totals and ordering rules.
module tb_hp_class_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] class_mask = 6'd0;
  logic       f_ready = 1'b0;

  logic        busy0, done0, busy1, done1;
  logic [16:0] count0, count1;

  hp_class_gen_if if0 ();
  hp_class_gen_if if1 ();

  assign if0.f_ready = f_ready;
  assign if1.f_ready = f_ready;

  hp_class_gen #(.POS_ONLY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .class_mask(class_mask), .fo(if0.master),
    .busy(busy0), .done(done0), .count(count0)
  );

  hp_class_gen #(.POS_ONLY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .class_mask(class_mask), .fo(if1.master),
    .busy(busy1), .done(done1), .count(count1)
  );

  always #5 clk = ~clk;

  logic [15:0] mf [2];
  logic        mv [2];
  logic        md [2];
  always_comb begin
    mf[0] = if0.f;  mv[0] = if0.f_valid;  md[0] = done0;
    mf[1] = if1.f;  mv[1] = if1.f_valid;  md[1] = done1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_mask(input logic [15:0] x, input logic [5:0] m);
    logic [5:0] c;
    if (x[14:10] == 5'd31)
      c = (x[9:0] == 10'd0) ? 6'b001000 : (x[9] ? 6'b010000 : 6'b100000);
    else if (x[14:10] == 5'd0)
      c = (x[9:0] == 10'd0) ? 6'b000100 : 6'b000010;
    else
      c = 6'b000001;
    return |(c & m);
  endfunction

  int hs [2], first_v [2], last_v [2], first_cyc [2], done_cyc [2];
  int err_cls [2], err_ord [2], err_stall [2], vld_seen [2];
  bit fin [2];
  int late_done;

  // One sweep on both instances; ends on both done pulses, on abort, or on the cycle budget.
  task automatic run(input logic [5:0] mask, input bit rnd, input bit contig, input int abort_after);
    bit          stall_prev [2];
    logic [15:0] pf [2];
    bit          aborted;
    int          cyc;
    for (int d = 0; d < 2; d++) begin
      hs[d] = 0; first_v[d] = -1; last_v[d] = -1; first_cyc[d] = -1; done_cyc[d] = -1;
      err_cls[d] = 0; err_ord[d] = 0; err_stall[d] = 0; vld_seen[d] = 0;
      fin[d] = 1'b0; stall_prev[d] = 1'b0; pf[d] = 16'd0;
    end
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; class_mask = mask;
    @(negedge clk);
    start = 1'b0; class_mask = ~mask;
    cyc = 1;
    while (cyc <= 75000) begin
      for (int d = 0; d < 2; d++) begin
        if (!fin[d]) begin
          if (stall_prev[d] && (!mv[d] || mf[d] != pf[d])) err_stall[d]++;
          if (md[d]) begin fin[d] = 1'b1; done_cyc[d] = cyc; end
          if (mv[d]) vld_seen[d]++;
          if (contig && hs[d] > 0 && !mv[d]) err_ord[d]++;
        end
      end
      if (fin[0] && fin[1]) break;
      if (abort_after > 0 && hs[0] >= abort_after) begin
        abort = 1'b1; f_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        aborted = 1'b1;
        break;
      end
      f_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (!fin[d]) begin
          if (mv[d] && f_ready) begin
            if (hs[d] == 0) begin
              first_v[d] = int'(mf[d]); first_cyc[d] = cyc;
            end else if (contig ? (int'(mf[d]) != last_v[d] + 1) : (int'(mf[d]) <= last_v[d])) begin
              err_ord[d]++;
            end
            if (!in_mask(mf[d], mask) || (d == 1 && mf[d][15])) err_cls[d]++;
            last_v[d] = int'(mf[d]);
            hs[d]++;
          end
          stall_prev[d] = mv[d] && !f_ready;
          pf[d] = mf[d];
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!aborted && !(fin[0] && fin[1])) check("sweep_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic watch_done(input int n);
    late_done = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done0 || done1) late_done++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_f", 32'(if0.f), 32'h0);
    check("rst_f_valid", 32'(if0.f_valid), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_count", 32'(count0), 32'h0);
    check("rst_f_valid_pos", 32'(if1.f_valid), 32'h0);

    // Empty mask: done two cycles after start, nothing streamed.
    run(6'd0, 1'b0, 1'b0, 0);
    check("m0_done_cyc", 32'(done_cyc[0]), 32'd2);
    check("m0_done_cyc_pos", 32'(done_cyc[1]), 32'd2);
    check("m0_count", 32'(count0), 32'd0);
    check("m0_vld_seen", 32'(vld_seen[0]), 32'd0);

    // All classes, full throughput, aborted after 300 handshakes.
    run(6'h3F, 1'b0, 1'b1, 300);
    check("all_first_v", 32'(first_v[0]), 32'h0);
    check("all_first_cyc", 32'(first_cyc[0]), 32'd2);
    check("all_gapless", 32'(err_ord[0]), 32'd0);
    check("all_last_v", 32'(last_v[0]), 32'd299);
    check("abort_f_valid", 32'(if0.f_valid), 32'h0);
    check("abort_busy", 32'(busy0), 32'h0);
    check("abort_busy_pos", 32'(busy1), 32'h0);
    check("abort_count", 32'(count0), 32'd300);
    check("abort_count_pos", 32'(count1), 32'd300);
    watch_done(4);
    check("abort_no_done", 32'(late_done), 32'd0);

    // start together with abort in IDLE starts nothing.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; class_mask = 6'h01;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy0), 32'h0);
    check("start_abort_count", 32'(count0), 32'd300);

    // Normals with random backpressure, aborted after 100.
    run(6'h01, 1'b1, 1'b0, 100);
    check("nrm_first_v", 32'(first_v[0]), 32'h0400);
    check("nrm_class", 32'(err_cls[0]), 32'd0);
    check("nrm_order", 32'(err_ord[0]), 32'd0);
    check("nrm_stall", 32'(err_stall[0]), 32'd0);
    check("nrm_count", 32'(count0), 32'd100);

    // Reset in the middle of a sweep is asynchronous.
    @(negedge clk);
    start = 1'b1; class_mask = 6'h3F; f_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_f_valid", 32'(if0.f_valid), 32'h0);
    check("midrst_busy", 32'(busy0), 32'h0);
    check("midrst_count", 32'(count0), 32'h0);
    check("midrst_f", 32'(if0.f), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // snan+infinity+subnormal, random backpressure, complete sweeps on both ranges.
    run(6'b101010, 1'b1, 1'b0, 0);
    check("mix_hs", 32'(hs[0]), 32'd3070);
    check("mix_count", 32'(count0), 32'd3070);
    check("mix_first", 32'(first_v[0]), 32'h0001);
    check("mix_last", 32'(last_v[0]), 32'hFDFF);
    check("mix_class", 32'(err_cls[0]), 32'd0);
    check("mix_order", 32'(err_ord[0]), 32'd0);
    check("mix_stall", 32'(err_stall[0]), 32'd0);
    check("mix_busy_end", 32'(busy0), 32'h0);
    check("pos_hs", 32'(hs[1]), 32'd1535);
    check("pos_count", 32'(count1), 32'd1535);
    check("pos_last", 32'(last_v[1]), 32'h7DFF);
    check("pos_class", 32'(err_cls[1]), 32'd0);
    check("pos_order", 32'(err_ord[1]), 32'd0);
    check("pos_stall", 32'(err_stall[1]), 32'd0);
    watch_done(2);
    check("count_hold", 32'(count0), 32'd3070);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
